// File: rtl/tape_frame_gen.sv
// Cassette-tape frame encoder: serialises bytes as start/data/parity/stop
// bits, each bit rendered as a square-wave burst timed by a phase accumulator.
module tape_frame_gen #(
    parameter int ACC_W     = 24,
    parameter int STOP_BITS = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ACC_W-1:0] step,
    input  logic             slow,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             busy,
    output logic             byte_done
);

    localparam int         LAST     = 8 + ((PARITY_EN != 0) ? 1 : 0) + STOP_BITS;
    localparam logic [4:0] LAST_IDX = 5'(LAST);
    localparam logic [4:0] PRE_LAST = 5'(LAST - 1);
    localparam logic [4:0] PAR_IDX  = 5'd9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       tc_q, tc_d;
    logic [4:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             slow_q, slow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [ACC_W:0]   sum;
    logic [3:0]       wrap;
    logic [2:0]       didx;
    logic             tick, bit_end, final_tick, load, cur_bit;

    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, step};
        tick       = (state_q != S_IDLE) && sum[ACC_W];
        wrap       = slow_q ? 4'd15 : 4'd3;
        bit_end    = tick && (tc_q == wrap);
        final_tick = bit_end && (state_q == S_LAST);
        din_ready  = (state_q == S_IDLE) || final_tick;
        load       = din_valid && din_ready;
    end

    // Bit index 0 is the start bit, 1..8 carry din[0]..din[7].
    always_comb begin
        didx = idx_q[2:0] - 3'd1;
        if (idx_q == 5'd0)
            cur_bit = 1'b0;
        else if (idx_q <= 5'd8)
            cur_bit = data_q[didx];
        else if (PARITY_EN != 0 && idx_q == PAR_IDX)
            cur_bit = ~^data_q;
        else
            cur_bit = 1'b1;

        if (state_q == S_IDLE)
            dout = 1'b1;
        else if (slow_q)
            dout = cur_bit ? ~tc_q[1] : ~tc_q[2];
        else
            dout = cur_bit ? ~tc_q[0] : ~tc_q[1];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tc_d    = tc_q;
        idx_d   = idx_q;
        data_d  = data_q;
        slow_d  = slow_q;
        done_d  = final_tick;

        if (state_q != S_IDLE)
            acc_d = sum[ACC_W-1:0];

        if (tick) begin
            if (bit_end) begin
                tc_d  = 4'd0;
                idx_d = idx_q + 5'd1;
            end else begin
                tc_d = tc_q + 4'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    tc_d    = 4'd0;
                    idx_d   = 5'd0;
                    data_d  = din;
                    slow_d  = slow;
                end
            end
            S_RUN: begin
                if (bit_end && idx_q == PRE_LAST)
                    state_d = S_LAST;
            end
            S_LAST: begin
                if (final_tick) begin
                    tc_d  = 4'd0;
                    idx_d = 5'd0;
                    if (load) begin
                        state_d = S_RUN;
                        data_d  = din;
                        slow_d  = slow;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            tc_q    <= 4'd0;
            idx_q   <= 5'd0;
            data_q  <= 8'd0;
            slow_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tc_q    <= tc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            slow_q  <= slow_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign byte_done = done_q;

    // LAST_IDX documents the frame length; the FSM keys off PRE_LAST.
    logic unused_last;
    assign unused_last = ^LAST_IDX;

endmodule

// File: tb/tb_tape_frame_gen.sv
// Directed bench for tape_frame_gen: default build plus a
// no-parity, three-stop-bit build on the same clock.
module tb_tape_frame_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] step, step2;
    logic        slow, slow2;
    logic [7:0]  din, din2;
    logic        din_valid, din_valid2;
    logic        din_ready, din_ready2;
    logic        dout, dout2;
    logic        busy, busy2;
    logic        byte_done, byte_done2;

    int checks   = 0;
    int failures = 0;
    logic rec [0:1023];

    always #5 clk = ~clk;

    tape_frame_gen u_dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .slow      (slow),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .busy      (busy),
        .byte_done (byte_done)
    );

    tape_frame_gen #(.ACC_W(24), .STOP_BITS(3), .PARITY_EN(0)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .step      (step2),
        .slow      (slow2),
        .din       (din2),
        .din_valid (din_valid2),
        .din_ready (din_ready2),
        .dout      (dout2),
        .busy      (busy2),
        .byte_done (byte_done2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat8(input int off);
        logic [7:0] p;
        for (int k = 0; k < 8; k++) p[7-k] = rec[off+k];
        return p;
    endfunction

    function automatic logic [31:0] pat32(input int off);
        logic [31:0] p;
        for (int k = 0; k < 32; k++) p[31-k] = rec[off+k];
        return p;
    endfunction

    task automatic do_load(input bit sel, input logic [7:0] d, input logic s);
        if (sel) begin
            din2 = d; slow2 = s; din_valid2 = 1'b1;
        end else begin
            din = d; slow = s; din_valid = 1'b1;
        end
        cyc();
        din_valid  = 1'b0;
        din_valid2 = 1'b0;
    endtask

    // Called in frame cycle 0; stops in the cycle busy falls.
    task automatic run_frame(input bit sel, input int max_c,
                             output int nb, output int nd);
        logic b, bd;
        nb = 0;
        nd = 0;
        for (int i = 0; i < max_c; i++) begin
            b  = sel ? busy2 : busy;
            bd = sel ? byte_done2 : byte_done;
            if (i < 1024) rec[i] = sel ? dout2 : dout;
            if (b) nb++;
            if (bd) nd++;
            if (!b) break;
            cyc();
        end
    endtask

    initial begin
        int nb, nd, nl, ndn, drops, changes, bad_busy;
        int ld [2];
        int dn [2];
        bit pend;
        logic d0;

        reset = 1'b1;
        step = 24'h800000; step2 = 24'h800000;
        slow = 1'b0; slow2 = 1'b0;
        din = 8'h00; din2 = 8'h00;
        din_valid = 1'b0; din_valid2 = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_dout", dout, 1'b1);
        chk("rst_ready", din_ready, 1'b1);
        chk("rst_done", byte_done, 1'b0);

        // Fast frame, din=01.
        do_load(0, 8'h01, 1'b0);
        run_frame(0, 200, nb, nd);
        chk("fast_busy_len", nb, 88);
        chk("fast_done_cnt", nd, 1);
        chk("fast_start", pat8(0), 8'hF0);
        chk("fast_d0_one", pat8(8), 8'hCC);
        chk("fast_d1_zero", pat8(16), 8'hF0);
        chk("fast_parity0", pat8(72), 8'hF0);
        chk("fast_stop", pat8(80), 8'hCC);
        chk("fast_idle_dout", dout, 1'b1);

        // Slow frame, din=FF.
        cyc();
        do_load(0, 8'hFF, 1'b1);
        run_frame(0, 600, nb, nd);
        chk("slow_busy_len", nb, 352);
        chk("slow_done_cnt", nd, 1);
        chk("slow_start", pat32(0), 32'hFF00FF00);
        chk("slow_d0", pat32(32), 32'hF0F0F0F0);
        chk("slow_d7", pat32(256), 32'hF0F0F0F0);
        chk("slow_parity1", pat32(288), 32'hF0F0F0F0);

        // Back-to-back A5 then 3C with din_valid held.
        cyc();
        slow = 1'b0; din = 8'hA5; din_valid = 1'b1;
        nl = 0; ndn = 0; drops = 0; pend = 0;
        ld[0] = 0; ld[1] = 0; dn[0] = 0; dn[1] = 0;
        for (int i = 0; i < 400; i++) begin
            if (pend) begin
                if (nl < 2) ld[nl] = i;
                nl++;
                pend = 0;
                if (nl == 1) din = 8'h3C;
                else din_valid = 1'b0;
            end
            if (byte_done) begin
                if (ndn < 2) dn[ndn] = i;
                ndn++;
            end
            if (!busy) begin
                if (nl >= 2 && ndn >= 2) break;
                else if (nl >= 1) drops++;
            end
            if (din_valid && din_ready) pend = 1;
            cyc();
        end
        din_valid = 1'b0;
        chk("b2b_loads", nl, 2);
        chk("b2b_load_gap", ld[1] - ld[0], 88);
        chk("b2b_busy_drops", drops, 0);
        chk("b2b_done_cnt", ndn, 2);
        chk("b2b_done_gap", dn[1] - dn[0], 88);

        // Reset in the middle of bit 4.
        cyc();
        do_load(0, 8'h01, 1'b0);
        for (int i = 0; i < 35; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_dout", dout, 1'b1);
        chk("mid_rst_ready", din_ready, 1'b1);
        nd = byte_done ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (byte_done) nd++;
        end
        chk("mid_rst_no_done", nd, 0);
        din = 8'h01; din_valid = 1'b1; reset = 1'b1;
        cyc();
        din_valid = 1'b0; reset = 1'b0;
        chk("rst_beats_load", busy, 1'b0);
        do_load(0, 8'h01, 1'b0);
        run_frame(0, 200, nb, nd);
        chk("post_rst_len", nb, 88);
        chk("post_rst_start", pat8(0), 8'hF0);
        chk("post_rst_done", nd, 1);

        // Frozen with step=0 for 1000 clocks.
        cyc();
        do_load(0, 8'h01, 1'b0);
        nb = busy ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (busy) nb++;
        end
        step = 24'h0;
        d0 = dout;
        changes = 0; bad_busy = 0; ndn = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (busy) nb++;
            if (dout !== d0) changes++;
            if (busy !== 1'b1) bad_busy++;
            if (byte_done) ndn++;
        end
        chk("freeze_dout", changes, 0);
        chk("freeze_busy", bad_busy, 0);
        chk("freeze_done", ndn, 0);
        step = 24'h800000;
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (busy) nb++;
            if (byte_done) nd++;
            if (!busy) break;
        end
        chk("freeze_total", nb, 1088);
        chk("freeze_done_after", nd, 1);

        // No parity, three stop bits.
        cyc();
        do_load(1, 8'h01, 1'b0);
        run_frame(1, 200, nb, nd);
        chk("np_busy_len", nb, 96);
        chk("np_done_cnt", nd, 1);
        chk("np_d7_zero", pat8(64), 8'hF0);
        chk("np_stop_after_d7", pat8(72), 8'hCC);
        chk("np_last_stop", pat8(88), 8'hCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
